// File: rtl/systolic_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// systolic_pkg : shared types and helpers for the multi-precision systolic PE
// Rev 1.0 - initial release
// ============================================================================
package systolic_pkg;

  typedef enum logic [1:0] {
    MODE_1B = 2'd0,
    MODE_2B = 2'd1,
    MODE_4B = 2'd2,
    MODE_8B = 2'd3
  } pe_mode_t;

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_LOADING = 2'd1,
    ST_READY   = 2'd2
  } pe_state_t;

  // Product headroom: decoded weights never exceed 8 signed bits.
  localparam int unsigned PROD_EXT = 8;

  function automatic logic signed [63:0] saturate(input logic signed [63:0] v,
                                                  input int width);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pe_weight_mult.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// pe_weight_mult : weight decode, multiply, fixed-point shift, accumulate, clamp
// Rev 1.0 - initial release
// ============================================================================
module pe_weight_mult
  import systolic_pkg::*;
#(
  parameter int BitSize        = 8,
  parameter int Weight_BitSize = 8,
  parameter int FixedPointPos  = 0,
  parameter int Saturate       = 1
) (
  input  pe_mode_t                    i_mode,
  input  logic [Weight_BitSize-1:0]   i_b,
  input  logic signed [BitSize-1:0]   i_a,
  input  logic signed [BitSize-1:0]   i_psum,
  output logic [BitSize-1:0]          o_result,
  output logic                        o_overflow
);

  localparam int c_PW = BitSize + int'(PROD_EXT);
  localparam int c_SW = c_PW + 1;

  logic [7:0]               w_b8;
  logic signed [7:0]        w_weight;
  logic signed [c_PW-1:0]   w_prod;
  logic signed [c_PW-1:0]   w_shift;
  logic signed [c_SW-1:0]   w_sum;
  logic signed [63:0]       w_sum64;
  logic signed [63:0]       w_sat;

  // Narrow weight buses are sign-extended so 8-bit mode sees a signed value.
  generate
    if (Weight_BitSize >= 8) begin : g_pad_wide
      assign w_b8 = i_b[7:0];
    end else begin : g_pad_narrow
      assign w_b8 = {{(8 - Weight_BitSize){i_b[Weight_BitSize-1]}}, i_b};
    end
  endgenerate

  always_comb begin
    w_weight = w_b8;
    case (i_mode)
      MODE_1B: w_weight = w_b8[0] ? 8'sd1 : -8'sd1;
      MODE_2B: w_weight = {{6{w_b8[1]}}, w_b8[1:0]};
      MODE_4B: w_weight = {{4{w_b8[3]}}, w_b8[3:0]};
      default: w_weight = w_b8;
    endcase
  end

  assign w_prod  = $signed({{PROD_EXT{i_a[BitSize-1]}}, i_a}) *
                   $signed({{BitSize{w_weight[7]}}, w_weight});
  assign w_shift = w_prod >>> FixedPointPos;
  assign w_sum   = $signed({w_shift[c_PW-1], w_shift}) +
                   $signed({{(c_SW - BitSize){i_psum[BitSize-1]}}, i_psum});
  assign w_sum64 = {{(64 - c_SW){w_sum[c_SW-1]}}, w_sum};
  assign w_sat   = saturate(w_sum64, BitSize);

  assign o_overflow = (w_sat != w_sum64);
  assign o_result   = (Saturate != 0) ? w_sat[BitSize-1:0] : w_sum[BitSize-1:0];

endmodule
`default_nettype wire

// File: rtl/systolic_pe_mp.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// systolic_pe_mp : multi-precision systolic PE with a preloaded weight ring
// Rev 1.0 - initial release
// ============================================================================
module systolic_pe_mp
  import systolic_pkg::*;
#(
  parameter int BitSize        = 8,
  parameter int Weight_BitSize = 8,
  parameter int Depth          = 4,
  parameter int Offset         = 0,
  parameter int FixedPointPos  = 0,
  parameter int Saturate       = 1
) (
  input  logic                        clk,
  input  logic                        res,
  input  logic [1:0]                  in_mode,
  input  logic                        en_l_b,
  input  logic [Weight_BitSize-1:0]   in_b,
  output logic [Weight_BitSize-1:0]   out_b,
  output logic                        out_l_b,
  input  logic                        in_valid,
  input  logic                        in_increment,
  input  logic signed [BitSize-1:0]   in_a,
  input  logic signed [BitSize-1:0]   in_partial_sum,
  output logic                        in_ready,
  output logic                        out_valid,
  output logic                        out_increment,
  output logic                        out_overflow,
  output logic                        out_loaded,
  output logic signed [BitSize-1:0]   out_a,
  output logic signed [BitSize-1:0]   out_partial_sum,
  input  logic                        out_ready
);

  localparam int                c_PTR_W     = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int                c_CNT_W     = $clog2(Depth + 1);
  localparam logic [c_PTR_W-1:0] c_PTR_START = c_PTR_W'(Offset % Depth);
  localparam logic [c_PTR_W-1:0] c_PTR_LAST  = c_PTR_W'(Depth - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_LAST  = c_CNT_W'(Depth - 1);

  pe_state_t                    r_state;
  pe_state_t                    w_state_nxt;
  pe_mode_t                     r_mode;
  logic [Weight_BitSize-1:0]    r_w [Depth];
  logic [c_CNT_W-1:0]           r_cnt;
  logic [c_PTR_W-1:0]           r_ptr;
  logic [c_PTR_W-1:0]           w_ptr_nxt;
  logic                         w_start;
  logic                         w_store;
  logic                         w_fire;
  logic [Weight_BitSize-1:0]    w_cur_b;
  logic [BitSize-1:0]           w_result;
  logic                         w_ovf;

  logic                         r_valid;
  logic                         r_inc;
  logic                         r_ovf;
  logic signed [BitSize-1:0]    r_a;
  logic signed [BitSize-1:0]    r_psum;
  logic [Weight_BitSize-1:0]    r_b;
  logic                         r_l_b;

  always_ff @(posedge clk or posedge res) begin
    if (res) r_state <= ST_EMPTY;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_store     = 1'b0;
    case (r_state)
      ST_EMPTY, ST_READY: begin
        if (en_l_b) begin
          w_start     = 1'b1;
          w_state_nxt = (Depth == 1) ? ST_READY : ST_LOADING;
        end
      end
      ST_LOADING: begin
        if (en_l_b) begin
          w_store = 1'b1;
          if (r_cnt == c_CNT_LAST) w_state_nxt = ST_READY;
        end
      end
      default: w_state_nxt = ST_EMPTY;
    endcase
  end

  assign in_ready  = (r_state == ST_READY) && !en_l_b && (!r_valid || out_ready);
  assign w_fire    = in_valid && in_ready;
  assign w_ptr_nxt = !in_increment        ? r_ptr :
                     (r_ptr == c_PTR_LAST) ? '0    : r_ptr + 1'b1;
  assign w_cur_b   = r_w[r_ptr];

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      for (int i = 0; i < Depth; i++) r_w[i] <= '0;
      r_cnt  <= '0;
      r_mode <= MODE_1B;
    end else if (w_start) begin
      r_w[0] <= in_b;
      r_cnt  <= c_CNT_W'(1);
      r_mode <= pe_mode_t'(in_mode);
    end else if (w_store) begin
      r_w[r_cnt[c_PTR_W-1:0]] <= in_b;
      r_cnt                   <= r_cnt + 1'b1;
    end
  end

  pe_weight_mult #(
    .BitSize        (BitSize),
    .Weight_BitSize (Weight_BitSize),
    .FixedPointPos  (FixedPointPos),
    .Saturate       (Saturate)
  ) u_mult (
    .i_mode     (r_mode),
    .i_b        (w_cur_b),
    .i_a        (in_a),
    .i_psum     (in_partial_sum),
    .o_result   (w_result),
    .o_overflow (w_ovf)
  );

  // Output register is independent of the load FSM so a reload never drops a pending beat.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      r_ptr   <= c_PTR_START;
      r_valid <= 1'b0;
      r_inc   <= 1'b0;
      r_ovf   <= 1'b0;
      r_a     <= '0;
      r_psum  <= '0;
      r_b     <= '0;
      r_l_b   <= 1'b0;
    end else begin
      r_b   <= in_b;
      r_l_b <= en_l_b;
      if (w_start)     r_ptr <= c_PTR_START;
      else if (w_fire) r_ptr <= w_ptr_nxt;
      if (w_fire) begin
        r_valid <= 1'b1;
        r_inc   <= in_increment;
        r_ovf   <= w_ovf;
        r_a     <= in_a;
        r_psum  <= w_result;
      end else if (out_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign out_b           = r_b;
  assign out_l_b         = r_l_b;
  assign out_valid       = r_valid;
  assign out_increment   = r_inc;
  assign out_overflow    = r_ovf;
  assign out_a           = r_a;
  assign out_partial_sum = r_psum;
  assign out_loaded      = (r_state == ST_READY);

endmodule
`default_nettype wire

// File: tb/tb_systolic_pe_mp.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_systolic_pe_mp : scoreboard bench for systolic_pe_mp (8-bit, depth 4)
// Rev 1.0 - initial release
// ============================================================================
module tb_systolic_pe_mp;

  localparam int c_BW    = 8;
  localparam int c_WB    = 8;
  localparam int c_DEPTH = 4;

  logic                     clk = 1'b0;
  logic                     res;
  logic [1:0]               in_mode;
  logic                     en_l_b;
  logic [c_WB-1:0]          in_b;
  logic [c_WB-1:0]          out_b;
  logic                     out_l_b;
  logic                     in_valid;
  logic                     in_increment;
  logic signed [c_BW-1:0]   in_a;
  logic signed [c_BW-1:0]   in_partial_sum;
  logic                     in_ready;
  logic                     out_valid;
  logic                     out_increment;
  logic                     out_overflow;
  logic                     out_loaded;
  logic signed [c_BW-1:0]   out_a;
  logic signed [c_BW-1:0]   out_partial_sum;
  logic                     out_ready;

  always #5 clk = ~clk;

  systolic_pe_mp #(
    .BitSize(c_BW), .Weight_BitSize(c_WB), .Depth(c_DEPTH),
    .Offset(0), .FixedPointPos(0), .Saturate(1)
  ) dut (
    .clk(clk), .res(res), .in_mode(in_mode), .en_l_b(en_l_b), .in_b(in_b),
    .out_b(out_b), .out_l_b(out_l_b), .in_valid(in_valid),
    .in_increment(in_increment), .in_a(in_a), .in_partial_sum(in_partial_sum),
    .in_ready(in_ready), .out_valid(out_valid), .out_increment(out_increment),
    .out_overflow(out_overflow), .out_loaded(out_loaded), .out_a(out_a),
    .out_partial_sum(out_partial_sum), .out_ready(out_ready)
  );

  typedef struct {
    int psum;
    int ovf;
    int a;
    int inc;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   m_w [c_DEPTH];
  int   m_ptr    = 0;

  task automatic check_eq(input string tag, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  function automatic int decode(input int mode, input logic [7:0] b);
    logic signed [1:0] s2;
    logic signed [3:0] s4;
    logic signed [7:0] s8;
    s2 = b[1:0];
    s4 = b[3:0];
    s8 = b;
    case (mode)
      0:       return b[0] ? 1 : -1;
      1:       return int'(s2);
      2:       return int'(s4);
      default: return int'(s8);
    endcase
  endfunction

  function automatic exp_t model(input int a, input int ps, input bit inc);
    exp_t e;
    int   v;
    v     = a * m_w[m_ptr] + ps;
    e.ovf = 0;
    if (v > 127)       begin v = 127;  e.ovf = 1; end
    else if (v < -128) begin v = -128; e.ovf = 1; end
    e.psum = v;
    e.a    = a;
    e.inc  = int'(inc);
    return e;
  endfunction

  // Compare each DUT beat against the oldest expected result.
  always @(posedge clk) begin
    bit   fired;
    exp_t e;
    fired = in_valid && in_ready && !res;
    #1;
    if (fired) begin
      if (sb.size() == 0) begin
        check_eq("sb_underflow", 1, 0);
      end else begin
        e = sb.pop_front();
        check_eq("beat_valid", out_valid, 1);
        check_eq("beat_psum", out_partial_sum, e.psum);
        check_eq("beat_ovf", out_overflow, e.ovf);
        check_eq("beat_a", out_a, e.a);
        check_eq("beat_inc", out_increment, e.inc);
      end
    end
  end

  task automatic send(input int a, input int ps, input bit inc);
    int n = 0;
    @(negedge clk);
    in_a           = c_BW'(a);
    in_partial_sum = c_BW'(ps);
    in_increment   = inc;
    in_valid       = 1'b1;
    #1;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!in_ready) begin
      check_eq("send_timeout", 0, 1);
    end else begin
      sb.push_back(model(a, ps, inc));
      if (inc) m_ptr = (m_ptr + 1) % c_DEPTH;
    end
    @(posedge clk);
    #2;
    in_valid = 1'b0;
  endtask

  task automatic load(input int mode, input logic [7:0] b0, input logic [7:0] b1,
                      input logic [7:0] b2, input logic [7:0] b3);
    logic [7:0] bs [4];
    bs = '{b0, b1, b2, b3};
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k > 0) check_eq("loaded_mid", out_loaded, 0);
      en_l_b  = 1'b1;
      in_mode = 2'(mode);
      in_b    = bs[k];
      m_w[k]  = decode(mode, bs[k]);
    end
    @(negedge clk);
    check_eq("loaded", out_loaded, 1);
    check_eq("chain_b", out_b, bs[3]);
    check_eq("chain_l", out_l_b, 1);
    en_l_b = 1'b0;
    m_ptr  = 0;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout, expected completion");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    res = 1'b1; in_mode = 2'd3; en_l_b = 1'b0; in_b = '0; in_valid = 1'b0;
    in_increment = 1'b0; in_a = '0; in_partial_sum = '0; out_ready = 1'b1;
    #12;
    check_eq("rst_valid", out_valid, 0);
    check_eq("rst_loaded", out_loaded, 0);
    check_eq("rst_ready", in_ready, 0);
    check_eq("rst_psum", out_partial_sum, 0);
    check_eq("rst_b", out_b, 0);
    @(negedge clk);
    res = 1'b0;

    load(3, 8'd3, 8'hFE, 8'd5, 8'd1);
    #1;
    check_eq("ready_after_load", in_ready, 1);
    repeat (5) send(10, 0, 1);
    repeat (3) send(0, 0, 1);
    send(100, 0, 0);
    send(-100, 0, 1);

    @(posedge clk);
    #1;
    check_eq("valid_fall", out_valid, 0);

    out_ready = 1'b0;
    send(20, 0, 1);
    in_a = 8'sd5; in_partial_sum = '0; in_increment = 1'b1; in_valid = 1'b1;
    repeat (2) begin
      @(negedge clk);
      #1;
      check_eq("hold_ready", in_ready, 0);
      check_eq("hold_valid", out_valid, 1);
      check_eq("hold_psum", out_partial_sum, -40);
      check_eq("hold_a", out_a, 20);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    send(5, 0, 1);

    out_ready = 1'b0;
    load(0, 8'h01, 8'h00, 8'h01, 8'h01);
    check_eq("reload_pend_valid", out_valid, 1);
    check_eq("reload_pend_psum", out_partial_sum, 25);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check_eq("reload_drain", out_valid, 0);
    send(7, 5, 1);
    send(7, 5, 1);

    load(2, 8'hF7, 8'h0C, 8'h38, 8'h19);
    repeat (4) send(3, 1, 1);

    check_eq("pre_reset_valid", out_valid, 1);
    #1 res = 1'b1;
    #1;
    check_eq("arst_valid", out_valid, 0);
    check_eq("arst_psum", out_partial_sum, 0);
    check_eq("arst_loaded", out_loaded, 0);
    check_eq("arst_ready", in_ready, 0);
    check_eq("arst_l_b", out_l_b, 0);
    res = 1'b0;
    in_a = 8'sd10; in_partial_sum = '0; in_increment = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    #1;
    check_eq("post_rst_ready", in_ready, 0);
    check_eq("post_rst_loaded", out_loaded, 0);
    @(posedge clk);
    #1;
    check_eq("post_rst_no_beat", out_valid, 0);
    in_valid = 1'b0;

    load(3, 8'd3, 8'hFE, 8'd5, 8'd1);
    send(10, 0, 1);
    @(posedge clk);
    #2;
    check_eq("sb_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
